// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, a mask register, and a three-state request/service handshake.
// Optional macro IRQ_ROUND_ROBIN_EN selects rotating-priority arbitration instead of lowest-index-first.
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             ir_req,
  input  logic             ir_ack,
  input  logic             eret,
  output logic [ID_W-1:0]  ir_id,
  output logic             ir_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] enabled;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] pending_nxt;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  ir_id_nxt;
  logic             ack_fire;

  assign edge_det = irq_src & ~prev;
  assign enabled  = pending & mask;
  assign ir_busy  = (state != IDLE);

  // A clear and a new edge on the same bit in the same cycle leave the bit set.
  assign clr_vec     = ack_fire ? ({{(N_SRC-1){1'b0}}, 1'b1} << ir_id) : '0;
  assign pending_nxt = (pending & ~clr_vec) | edge_det;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  logic            rr_found;
  int              rr_idx;

  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= N_SRC) rr_idx = rr_idx - N_SRC;
      if (!rr_found && enabled[rr_idx]) begin
        winner   = ID_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (ack_fire) begin
      rr_ptr <= (ir_id == ID_W'(N_SRC - 1)) ? '0 : ir_id + 1'b1;
    end
  end
`else
  // Scanning downwards lets the lowest enabled index overwrite any higher one.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (enabled[i]) winner = ID_W'(i);
    end
  end
`endif

  // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    ir_id_nxt = ir_id;
    ack_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (|enabled) begin
          state_nxt = REQ;
          ir_id_nxt = winner;
        end
      end
      REQ: begin
        if (ir_ack) begin
          ack_fire  = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (eret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev    <= '0;
      pending <= '0;
      mask    <= '1;
      ir_id   <= '0;
      ir_req  <= 1'b0;
    end else begin
      state   <= state_nxt;
      prev    <= irq_src;
      pending <= pending_nxt;
      ir_id   <= ir_id_nxt;
      ir_req  <= (state_nxt == REQ);
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (default fixed-priority build): a per-cycle vector table plus hand sequences
// for reset-held sources, set-wins-over-clear and masking while a request is outstanding.
module tb_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       ir_req;
  logic       ir_ack;
  logic       eret;
  logic [2:0] ir_id;
  logic       ir_busy;

  int checks;
  int failures;

  irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_src    (irq_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .ir_req     (ir_req),
    .ir_ack     (ir_ack),
    .eret       (eret),
    .ir_id      (ir_id),
    .ir_busy    (ir_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] src;
    logic       mwe;
    logic [7:0] mwd;
    logic       ack;
    logic       eret;
    logic [7:0] e_mask;
    logic [7:0] e_pend;
    logic       e_req;
    logic [2:0] e_id;
    logic       e_busy;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic r, input logic [7:0] s, input logic we, input logic [7:0] wd,
                      input logic a, input logic e);
    @(negedge clk);
    rst_n      = r;
    irq_src    = s;
    mask_we    = we;
    mask_wdata = wd;
    ir_ack     = a;
    eret       = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] m, input logic [7:0] p,
                           input logic rq, input logic [2:0] id, input logic b);
    check({tag, ".mask"},    32'(mask),    32'(m));
    check({tag, ".pending"}, 32'(pending), 32'(p));
    check({tag, ".ir_req"},  32'(ir_req),  32'(rq));
    check({tag, ".ir_id"},   32'(ir_id),   32'(id));
    check({tag, ".ir_busy"}, 32'(ir_busy), 32'(b));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    irq_src    = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    ir_ack     = 1'b0;
    eret       = 1'b0;

    //            rst  src    mwe  mwd    ack  eret   mask   pend   req  id    busy
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h20, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h20, 1'b1, 3'd5, 1'b1};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h20, 1'b1, 3'd5, 1'b1};
    vecs[5]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd5, 1'b1};
    vecs[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd5, 1'b1};
    vecs[7]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd5, 1'b0};
    vecs[8]  = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h44, 1'b0, 3'd5, 1'b0};
    vecs[9]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h44, 1'b1, 3'd2, 1'b1};
    vecs[10] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h40, 1'b0, 3'd2, 1'b1};
    vecs[11] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h40, 1'b0, 3'd2, 1'b0};
    vecs[12] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h40, 1'b1, 3'd6, 1'b1};
    vecs[13] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd6, 1'b1};
    vecs[14] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd6, 1'b0};
    vecs[15] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h10, 1'b0, 3'd6, 1'b0};
    vecs[16] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h10, 1'b1, 3'd4, 1'b1};
    vecs[17] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd4, 1'b1};
    vecs[18] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h10, 1'b0, 3'd4, 1'b1};
    vecs[19] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h10, 1'b0, 3'd4, 1'b1};
    vecs[20] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h10, 1'b0, 3'd4, 1'b0};
    vecs[21] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h10, 1'b1, 3'd4, 1'b1};
    vecs[22] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd4, 1'b1};
    vecs[23] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd4, 1'b0};
    vecs[24] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd4, 1'b0};
    vecs[25] = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 3'd4, 1'b0};
    vecs[26] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 3'd4, 1'b0};
    vecs[27] = '{1'b1, 8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 8'h08, 8'h08, 1'b0, 3'd4, 1'b0};
    vecs[28] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 8'h08, 1'b1, 3'd3, 1'b1};
    vecs[29] = '{1'b1, 8'h11, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'h11, 1'b0, 3'd3, 1'b1};
    vecs[30] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h11, 1'b0, 3'd3, 1'b0};
    vecs[31] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h11, 1'b1, 3'd0, 1'b1};
    vecs[32] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[33] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[34] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst_n, vecs[i].src, vecs[i].mwe, vecs[i].mwd, vecs[i].ack, vecs[i].eret);
      check_all($sformatf("vec%0d", i), vecs[i].e_mask, vecs[i].e_pend, vecs[i].e_req,
                vecs[i].e_id, vecs[i].e_busy);
    end

    // Source 1 held high across reset release: edge seen on the first cycle after release.
    step(1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    check_all("held_rst", 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    check_all("held_rel", 8'hFF, 8'h02, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_all("held_req", 8'hFF, 8'h02, 1'b1, 3'd1, 1'b1);

    // Masking the source while REQ is outstanding does not withdraw the request.
    step(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    check_all("mask_in_req", 8'h00, 8'h02, 1'b1, 3'd1, 1'b1);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_all("mask_in_req2", 8'h00, 8'h02, 1'b1, 3'd1, 1'b1);

    // New edge on source 1 in the same cycle as its ack: set wins over clear.
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0);
    check_all("set_wins", 8'h00, 8'h02, 1'b0, 3'd1, 1'b1);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    check_all("eret_masked", 8'h00, 8'h02, 1'b0, 3'd1, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_all("idle_masked", 8'h00, 8'h02, 1'b0, 3'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
